// File: rtl/nvdla_cdma_sync_fifo.sv
// nvdla_cdma_sync_fifo
// Single-clock valid/ready FIFO for CDMA pixel and side-band streams.
// The storage is a bank of flops and the read pointer is registered.
// Full and empty are decided from the occupancy count only.
// A runtime write limit caps the usable capacity.
// The block also provides a registered almost-full flag and a synchronous flush.
module nvdla_cdma_sync_fifo #(
    parameter int DATA_WIDTH = 11,
    parameter int DEPTH      = 128,
    parameter int CW         = $clog2(DEPTH + 1),
    parameter int AF_LEVEL   = DEPTH - 2
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  flush,
    input  logic                  wr_req,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_req,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [CW-1:0]         wr_limit,
    output logic [CW-1:0]         count,
    output logic                  almost_full,
    output logic                  idle
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage is deliberately left without reset; only the pointers and count carry state meaning.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          almost_full_q;
    logic          almost_full_d;

    logic [CW-1:0] eff_limit;
    logic          full;
    logic          push;
    logic          pop;

    // Capacity cap: a zero or out-of-range limit means the full depth.
    always_comb begin
        eff_limit = wr_limit;
        if ((wr_limit == '0) || (wr_limit > CW'(DEPTH))) begin
            eff_limit = CW'(DEPTH);
        end
    end

    // Handshake decode. A flush blocks the write and cancels any pop in the same cycle.
    assign full     = (count_q >= eff_limit);
    assign wr_ready = !full && !flush;
    assign rd_req   = (count_q != '0);
    assign push     = wr_req && wr_ready;
    assign pop      = rd_req && rd_ready && !flush;

    assign rd_data     = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign almost_full = almost_full_q;
    assign idle        = (count_q == '0) && !wr_req;

    // Next-state for pointers, count and almost-full. Flush overrides everything.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        almost_full_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
            almost_full_d = (count_d >= CW'(AF_LEVEL));
        end
    end

    // Payload write into the entry addressed by the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
        end
    end

    // Simulation-time sanity checks on the handshake and occupancy invariants.
    a_no_push_when_blocked : assert property (
        @(posedge clk) disable iff (!reset_) (wr_req && !wr_ready) |-> !push);

    a_head_stable_when_stalled : assert property (
        @(posedge clk) disable iff (!reset_)
        (rd_req && !rd_ready && !flush) |=> ($stable(rd_data) && rd_req));

    a_count_bounded : assert property (
        @(posedge clk) disable iff (!reset_) (count_q <= CW'(DEPTH)));

endmodule

// File: tb/tb_nvdla_cdma_sync_fifo.sv
// Bench for nvdla_cdma_sync_fifo.
// It uses DATA_WIDTH=11, DEPTH=8 and AF_LEVEL=6.
// Stimulus is driven from a table of vectors. Each vector holds the inputs for one cycle and the outputs expected before that cycle's clock edge.
// Hand-written sequences cover the asynchronous reset case.
module tb_nvdla_cdma_sync_fifo;

    localparam int DW    = 11;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset_;
    logic          flush;
    logic          wr_req;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] wr_limit;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          idle;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nvdla_cdma_sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF)
    ) dut (
        .clk         (clk),
        .reset_      (reset_),
        .flush       (flush),
        .wr_req      (wr_req),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .wr_limit    (wr_limit),
        .count       (count),
        .almost_full (almost_full),
        .idle        (idle)
    );

    typedef struct {
        logic          flush;
        logic          wr_req;
        logic [DW-1:0] wr_data;
        logic          rd_ready;
        logic [CW-1:0] wr_limit;
        logic [CW-1:0] e_count;
        logic          e_rd_req;
        logic [DW-1:0] e_rd_data;
        logic          e_wr_ready;
        logic          e_af;
        logic          e_idle;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic fl, input logic wq, input int wd, input logic rr,
                                input int wl, input int ec, input logic erq, input int erd,
                                input logic ewr, input logic eaf);
        vec_t v;
        v.flush      = fl;
        v.wr_req     = wq;
        v.wr_data    = DW'(wd);
        v.rd_ready   = rr;
        v.wr_limit   = CW'(wl);
        v.e_count    = CW'(ec);
        v.e_rd_req   = erq;
        v.e_rd_data  = DW'(erd);
        v.e_wr_ready = ewr;
        v.e_af       = eaf;
        v.e_idle     = (ec == 0) && !wq;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        // Fill with rd_ready low. almost_full is visible once 6 words are held.
        for (int k = 1; k <= 8; k++) add(0, 1, k, 0, 0, k - 1, k > 1, 1, 1, (k - 1) >= 6);
        add(0, 1, 9, 0, 0, 8, 1, 1, 0, 1);
        // Drain in order.
        for (int j = 1; j <= 8; j++) add(0, 0, 0, 1, 0, 9 - j, 1, j, j != 1, (9 - j) >= 6);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        // Streaming: one transfer per cycle after one cycle of latency.
        for (int i = 0; i < 20; i++) add(0, 1, 'h100 + i, 1, 0, (i == 0) ? 0 : 1, i != 0, 'h100 + i - 1, 1, 0);
        add(0, 0, 0, 1, 0, 1, 1, 'h113, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // Limit of 3: the producer holds the 4th word until the limit is lifted.
        add(0, 1, 'h200, 0, 3, 0, 0, 0, 1, 0);
        add(0, 1, 'h201, 0, 3, 1, 1, 'h200, 1, 0);
        add(0, 1, 'h202, 0, 3, 2, 1, 'h200, 1, 0);
        add(0, 1, 'h203, 0, 3, 3, 1, 'h200, 0, 0);
        add(0, 1, 'h203, 0, 3, 3, 1, 'h200, 0, 0);
        add(0, 1, 'h203, 0, 0, 3, 1, 'h200, 1, 0);
        add(0, 1, 'h204, 0, 0, 4, 1, 'h200, 1, 0);
        add(0, 0, 0, 0, 0, 5, 1, 'h200, 1, 0);
        // Backpressure: drop to 4, then rd_ready 1,0,0,1.
        add(0, 0, 0, 1, 0, 5, 1, 'h200, 1, 0);
        add(0, 0, 0, 1, 0, 4, 1, 'h201, 1, 0);
        add(0, 0, 0, 0, 0, 3, 1, 'h202, 1, 0);
        add(0, 0, 0, 0, 0, 3, 1, 'h202, 1, 0);
        add(0, 0, 0, 1, 0, 3, 1, 'h202, 1, 0);
        add(0, 0, 0, 0, 0, 2, 1, 'h203, 1, 0);
        // Flush at count 5 with a concurrent push and pop.
        add(0, 1, 'h300, 0, 0, 2, 1, 'h203, 1, 0);
        add(0, 1, 'h301, 0, 0, 3, 1, 'h203, 1, 0);
        add(0, 1, 'h302, 0, 0, 4, 1, 'h203, 1, 0);
        add(1, 1, 'h3AA, 1, 0, 5, 1, 'h203, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 'h7FF, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 1, 'h7FF, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        reset_   = 1'b0;
        flush    = 1'b0;
        wr_req   = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        wr_limit = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_count", int'(count), 0);
        check("reset_rd_req", int'(rd_req), 0);
        check("reset_wr_ready", int'(wr_ready), 1);
        check("reset_af", int'(almost_full), 0);
        check("reset_idle", int'(idle), 1);
        reset_ = 1'b1;

        foreach (vecs[n]) begin
            @(negedge clk);
            flush    = vecs[n].flush;
            wr_req   = vecs[n].wr_req;
            wr_data  = vecs[n].wr_data;
            rd_ready = vecs[n].rd_ready;
            wr_limit = vecs[n].wr_limit;
            #1;
            $display("vec %0d: fl=%0b wr=%0b wd=%h rr=%0b lim=%0d -> count=%0d rd_req=%0b rd_data=%h wr_ready=%0b af=%0b idle=%0b",
                     n, flush, wr_req, wr_data, rd_ready, wr_limit, count, rd_req, rd_data, wr_ready, almost_full, idle);
            check($sformatf("v%0d_count", n), int'(count), int'(vecs[n].e_count));
            check($sformatf("v%0d_rd_req", n), int'(rd_req), int'(vecs[n].e_rd_req));
            check($sformatf("v%0d_wr_ready", n), int'(wr_ready), int'(vecs[n].e_wr_ready));
            check($sformatf("v%0d_af", n), int'(almost_full), int'(vecs[n].e_af));
            check($sformatf("v%0d_idle", n), int'(idle), int'(vecs[n].e_idle));
            if (vecs[n].e_rd_req) begin
                check($sformatf("v%0d_rd_data", n), int'(rd_data), int'(vecs[n].e_rd_data));
            end
        end

        // Asynchronous reset while 6 words are held.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            flush    = 1'b0;
            rd_ready = 1'b0;
            wr_limit = '0;
            wr_req   = 1'b1;
            wr_data  = DW'('h010 + i);
        end
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        $display("pre-reset: count=%0d af=%0b rd_data=%h", count, almost_full, rd_data);
        check("prereset_count", int'(count), 6);
        check("prereset_af", int'(almost_full), 1);
        check("prereset_rd_data", int'(rd_data), 'h010);
        #1;
        reset_ = 1'b0;
        #1;
        $display("in reset: count=%0d rd_req=%0b wr_ready=%0b af=%0b", count, rd_req, wr_ready, almost_full);
        check("async_count", int'(count), 0);
        check("async_rd_req", int'(rd_req), 0);
        check("async_wr_ready", int'(wr_ready), 1);
        check("async_af", int'(almost_full), 0);
        @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);
        wr_req  = 1'b1;
        wr_data = DW'('h055);
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        $display("post-reset push: count=%0d rd_req=%0b rd_data=%h", count, rd_req, rd_data);
        check("resume_count", int'(count), 1);
        check("resume_rd_req", int'(rd_req), 1);
        check("resume_rd_data", int'(rd_data), 'h055);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        #1;
        $display("post-reset pop: count=%0d rd_req=%0b", count, rd_req);
        check("resume_drain_count", int'(count), 0);
        check("resume_drain_rd_req", int'(rd_req), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
